// File: rtl/spi_bos_responder.sv
// spi_bos_responder: 3-wire SPI (CPOL=1, CPHA=0) responder with a 16-bit register file
// Ports: clk/rst (async active-high) | sl chip select (active low), sck serial clock (idles high),
//        sdio bidirectional data | regs flat register file (reg k at [16*k+:16]) |
//        wr_addr/wr_data/wr_strobe last committed write | rd_strobe read load pulse |
//        frame_err aborted-frame pulse | sdio_oe responder drive enable
module spi_bos_responder #(
  parameter int N_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sl,
  input  logic                  sck,
  inout  wire                   sdio,
  output logic [16*N_REGS-1:0]  regs,
  output logic [6:0]            wr_addr,
  output logic [15:0]           wr_data,
  output logic                  wr_strobe,
  output logic                  rd_strobe,
  output logic                  frame_err,
  output logic                  sdio_oe
);
  localparam int AW = $clog2(N_REGS);
  localparam logic [7:0] NR = 8'(N_REGS);
  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_DATA, DONE} state_t;
  state_t state, next;
  logic [2:0] sl_p, sck_p;
  logic [1:0] sd_p;
  logic [4:0] cnt;
  logic [14:0] sh;
  logic [6:0] addr;
  logic [15:0] rsh, rd_val;
  logic [15:0] rf [N_REGS];
  logic sdo, oe_r;
  logic sl_fall, sl_rise, sck_fall, sck_rise, bit_in, last8, last24;
  logic [7:0] cmd;
  logic [15:0] wdat;
  // sl chain resets low so a select already asserted at reset release never looks like a frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sl_p  <= 3'b000;
      sck_p <= 3'b111;
      sd_p  <= 2'b00;
    end else begin
      sl_p  <= {sl_p[1:0], sl};
      sck_p <= {sck_p[1:0], sck};
      sd_p  <= {sd_p[0], sdio};
    end
  assign sl_fall  = sl_p[2] & ~sl_p[1];
  assign sl_rise  = ~sl_p[2] & sl_p[1];
  assign sck_fall = sck_p[2] & ~sck_p[1];
  assign sck_rise = ~sck_p[2] & sck_p[1];
  assign bit_in   = sck_fall && (state == CMD || state == WR_DATA || state == RD_DATA) && cnt != 5'd24;
  assign last8    = bit_in && state == CMD && cnt == 5'd7;
  assign last24   = bit_in && cnt == 5'd23;
  // command byte and write word include the bit being sampled this cycle
  assign cmd      = {sh[6:0], sd_p[1]};
  assign wdat     = {sh, sd_p[1]};
  assign rd_val   = ({1'b0, cmd[6:0]} < NR) ? rf[cmd[AW-1:0]] : 16'h0000;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (sl_rise) next = IDLE;
    else if (state == IDLE && sl_fall) next = CMD;
    else if (last8) next = cmd[7] ? RD_DATA : WR_DATA;
    else if (last24) next = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      sh        <= '0;
      addr      <= '0;
      rsh       <= '0;
      sdo       <= 1'b0;
      oe_r      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < N_REGS; i++) rf[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= last8 && cmd[7];
      frame_err <= sl_rise && state != IDLE && cnt != 5'd0 && cnt != 5'd24;
      if (sl_fall) cnt <= '0;
      else if (bit_in) cnt <= cnt + 5'd1;
      if (bit_in) sh <= {sh[13:0], sd_p[1]};
      if (last8) addr <= cmd[6:0];
      if (last8 && cmd[7]) rsh <= rd_val;
      if (last24 && state == WR_DATA && !sl_rise) begin
        wr_addr   <= addr;
        wr_data   <= wdat;
        wr_strobe <= 1'b1;
        if ({1'b0, addr} < NR) rf[addr[AW-1:0]] <= wdat;
      end
      if (sl_rise || state == IDLE || (state == DONE && sck_rise)) oe_r <= 1'b0;
      else if (state == RD_DATA && sck_rise) begin
        oe_r <= 1'b1;
        sdo  <= rsh[15];
        rsh  <= {rsh[14:0], 1'b0};
      end
    end
  // release the line in the very cycle the deselect is seen
  assign sdio_oe = oe_r && !sl_rise;
  assign sdio = sdio_oe ? sdo : 1'bz;
  for (genvar k = 0; k < N_REGS; k++) assign regs[16*k+:16] = rf[k];
endmodule

// File: tb/tb_spi_bos_responder.sv
// tb_spi_bos_responder: directed self-checking bench for spi_bos_responder
module tb_spi_bos_responder;
  logic clk = 1'b0, rst = 1'b1, sl = 1'b1, sck = 1'b1;
  logic host_oe = 1'b0, host_d = 1'b0;
  wire sdio;
  logic [255:0] regs;
  logic [6:0] wr_addr;
  logic [15:0] wr_data, q;
  logic wr_strobe, rd_strobe, frame_err, sdio_oe;
  logic [15:0] exp_r [16];
  int checks = 0, failures = 0;
  int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_cont = 0;
  int b_wr, b_rd, b_err, b_oe;

  spi_bos_responder #(.N_REGS(16)) dut (
    .clk(clk), .rst(rst), .sl(sl), .sck(sck), .sdio(sdio), .regs(regs),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe), .frame_err(frame_err), .sdio_oe(sdio_oe));

  assign sdio = host_oe ? host_d : 1'bz;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) n_wr++;
    if (rd_strobe) n_rd++;
    if (frame_err) n_err++;
    if (sdio_oe) n_oe++;
    if (sdio_oe && host_oe) n_cont++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] expv();
    logic [255:0] v = '0;
    for (int i = 0; i < 16; i++) v[16*i+:16] = exp_r[i];
    return v;
  endfunction

  task automatic mark();
    b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_oe = n_oe;
  endtask

  task automatic start();
    sl = 1'b0;
    #120;
  endtask

  task automatic stop();
    #60;
    host_oe = 1'b0;
    sl = 1'b1;
    #240;
  endtask

  // host clocks bits first..last-1; in read frames it releases sdio after bit 8 and samples on falling edges
  task automatic send(input logic [23:0] f, input int first, input int last, input logic rd);
    logic [23:0] fv;
    for (int i = first; i < last; i++) begin
      fv = f << i;
      host_oe = !(rd && i >= 8);
      host_d = fv[23];
      #60 sck = 1'b0;
      if (rd && i >= 8 && i < 24) q = {q[14:0], sdio};
      #60 sck = 1'b1;
    end
  endtask

  task automatic frame(input logic [23:0] f, input int nb, input logic rd);
    q = '0;
    start();
    send(f, 0, nb, rd);
    stop();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_r[i] = '0;
    #33 rst = 1'b0;
    #100;
    chk("reset_wr_addr", 256'(wr_addr), 256'd0);
    chk("reset_wr_data", 256'(wr_data), 256'd0);
    chk("reset_regs", regs, 256'd0);
    chk("reset_oe", 256'(sdio_oe), 256'd0);
    chk("reset_strobes", 256'(n_wr + n_rd + n_err), 256'd0);

    mark();
    start();
    send(24'h01BEEF, 0, 10, 1'b0);
    #3 rst = 1'b1;
    #27;
    chk("midrst_oe", 256'(sdio_oe), 256'd0);
    chk("midrst_regs", regs, 256'd0);
    #30 rst = 1'b0;
    #30;
    send(24'h01BEEF, 10, 24, 1'b0);
    stop();
    chk("midrst_no_write", 256'(n_wr - b_wr), 256'd0);
    chk("midrst_no_err", 256'(n_err - b_err), 256'd0);
    chk("midrst_regs_after", regs, 256'd0);

    mark();
    frame(24'h03A55A, 24, 1'b0);
    exp_r[3] = 16'hA55A;
    chk("wr3_strobe", 256'(n_wr - b_wr), 256'd1);
    chk("wr3_addr", 256'(wr_addr), 256'h03);
    chk("wr3_data", 256'(wr_data), 256'hA55A);
    chk("wr3_regs", regs, expv());
    chk("wr3_no_drive", 256'(n_oe - b_oe), 256'd0);

    mark();
    frame(24'h830000, 24, 1'b1);
    chk("rd3_strobe", 256'(n_rd - b_rd), 256'd1);
    chk("rd3_data", 256'(q), 256'hA55A);
    chk("rd3_drove", 256'(n_oe - b_oe > 100), 256'd1);
    chk("rd3_contention", 256'(n_cont), 256'd0);
    chk("rd3_released", 256'(sdio_oe), 256'd0);
    chk("rd3_no_write", 256'(n_wr - b_wr), 256'd0);

    mark();
    frame(24'h7F1234, 24, 1'b0);
    chk("oor_wr_strobe", 256'(n_wr - b_wr), 256'd1);
    chk("oor_wr_addr", 256'(wr_addr), 256'h7F);
    chk("oor_wr_data", 256'(wr_data), 256'h1234);
    chk("oor_regs", regs, expv());
    mark();
    frame(24'hFF0000, 24, 1'b1);
    chk("oor_rd_strobe", 256'(n_rd - b_rd), 256'd1);
    chk("oor_rd_data", 256'(q), 256'h0000);

    mark();
    frame(24'h05BEEF, 15, 1'b0);
    chk("abort_err", 256'(n_err - b_err), 256'd1);
    chk("abort_no_write", 256'(n_wr - b_wr), 256'd0);
    chk("abort_regs", regs, expv());
    mark();
    frame(24'h050F0F, 24, 1'b0);
    exp_r[5] = 16'h0F0F;
    chk("after_abort_write", 256'(n_wr - b_wr), 256'd1);
    chk("after_abort_regs", regs, expv());
    chk("after_abort_no_err", 256'(n_err - b_err), 256'd0);

    mark();
    sl = 1'b0;
    #100 sl = 1'b1;
    #200;
    chk("glitch_no_err", 256'(n_err - b_err), 256'd0);

    mark();
    frame(24'h0A1357, 30, 1'b0);
    exp_r[10] = 16'h1357;
    chk("overrun_write", 256'(n_wr - b_wr), 256'd1);
    chk("overrun_regs", regs, expv());
    chk("overrun_no_err", 256'(n_err - b_err), 256'd0);

    mark();
    start();
    send(24'h011111, 0, 24, 1'b0);
    #60 sl = 1'b1;
    #120 sl = 1'b0;
    #120;
    send(24'h022222, 0, 24, 1'b0);
    stop();
    exp_r[1] = 16'h1111;
    exp_r[2] = 16'h2222;
    chk("b2b_writes", 256'(n_wr - b_wr), 256'd2);
    chk("b2b_last_addr", 256'(wr_addr), 256'h02);
    chk("b2b_regs", regs, expv());
    chk("b2b_no_err", 256'(n_err - b_err), 256'd0);

    mark();
    frame(24'h810000, 24, 1'b1);
    chk("rd1_data", 256'(q), 256'h1111);
    chk("total_contention", 256'(n_cont), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_bos_responder.md
# spi_bos_responder

Responder (slave) end of the 3-wire bidirectional SPI control link to the SBIS BOS (sl/sck/sdio, CPOL=1, CPHA=0, 24-bit frames, direction swap after bit 8). Used as a behavioural and synthesizable stand-in for the SBIS BOS control port, for loopback boards and for closed-loop verification of the host-side SPI master. Holds a small 16-bit register file that is written and read over the link, and exposes it in parallel to the rest of the design.

## Interface
- N_REGS, 16: implemented registers, addresses 0..N_REGS-1 (N_REGS ≤ 128)
- clk  in  1  system clock; must be ≥ 8× sck frequency
- rst  in  1  asynchronous, active-high reset
- sl  in  1  chip select, active low
- sck  in  1  serial clock, idles high
- sdio  inout  1  bidirectional serial data; driven only while sdio_oe=1, else Z
- regs  out  16*N_REGS  register file, reg k at [16*k+:16]
- wr_addr  out  7  address of last committed write
- wr_data  out  16  data of last committed write
- wr_strobe  out  1  one-clk pulse per committed write
- rd_strobe  out  1  one-clk pulse when read data is loaded for shifting
- frame_err  out  1  one-clk pulse on aborted frame
- sdio_oe  out  1  internal drive enable, visible for debug

## Operation
- Frame, MSB first: bit 23 = R/W (1 = read), bits 22..16 = addr[6:0], bits 15..0 = data.
- sl, sck, sdio each pass a 2-flop synchronizer; sck falling/rising and sl falling/rising detected on synchronized copies.
- CPHA=0, CPOL=1: responder samples sdio on sck falling edge; drives read data changes on sck rising edge.
- Bit counter cnt (0..24) cleared on sl falling edge, increments on each sampled falling edge while sl low; saturates at 24.
- States: IDLE, CMD, WR_DATA, RD_DATA, DONE.
  - IDLE → CMD on sl falling edge.
  - CMD: shift 8 bits; at cnt=8 latch rw/addr. rw=0 → WR_DATA. rw=1 → RD_DATA: load shift reg with regs[addr] (0x0000 if addr ≥ N_REGS), pulse rd_strobe.
  - RD_DATA: on each sck rising edge (first one after bit 8 sampled) assert sdio_oe and present next data bit MSB first; after 16 bits presented, hold last bit until DONE.
  - WR_DATA: shift 16 bits; at cnt=24 commit: if addr < N_REGS update regs[addr]; always update wr_addr/wr_data and pulse wr_strobe (out-of-range: regs unchanged).
  - cnt=24 in any data state → DONE. DONE: ignore further sck edges, sdio_oe low after next sck rising edge or sl rise.
  - Any state: sl rising edge → IDLE, sdio_oe=0 same cycle as detection. If 1 ≤ cnt ≤ 23 at sl rise: pulse frame_err, no write commit.
- sl rising with cnt=0 (select glitch): IDLE, no error.
- Reset values: regs all 0x0000, wr_addr 0, wr_data 0, wr_strobe 0, rd_strobe 0, frame_err 0, sdio_oe 0 (sdio = Z), state IDLE, cnt 0.
- Reset released while sl low: stays IDLE until next sl falling edge; partial frame ignored, no frame_err.

## Timing
- Synchronizer + edge detect latency: 3 clk from pin transition to internal edge event.
- sdio_oe and first read bit valid ≤ 4 clk after sck rising edge following bit-8 sample; host must sample ≥ half sck period later (guaranteed at ≥ 8× ratio).
- Read bit n+1 appears ≤ 4 clk after the sck rising edge following bit n.
- wr_strobe, regs update, wr_addr/wr_data: same clk, 1 clk after the 24th falling-edge event.
- rd_strobe: 1 clk after the 8th falling-edge event.
- frame_err: 1 clk after sl rising event.
- sdio released ≤ 4 clk after sl rising pin edge.

## Test plan
- Reset: assert rst mid-frame → all outputs at reset values, sdio Z; release with sl low, finish frame → no write, no strobes.
- Write 0x03 ← 0xA55A (frame 0x03A55A) → one wr_strobe, wr_addr=0x03, wr_data=0xA55A, regs[3]=0xA55A, others 0, sdio never driven.
- Read 0x03 after above (frame 0x83 + 16 clocks) → rd_strobe once, host shifts 0xA55A, sdio_oe high only between bit 9 and sl rise.
- Out-of-range: write 0x7F ← 0x1234 → wr_strobe, wr_data=0x1234, regs unchanged; read 0x7F → 0x0000.
- Abort: write 0x05 with sl rising after 15 bits → frame_err one pulse, no wr_strobe, regs[5] unchanged; next full frame works.
- Overrun/back-to-back: 30 sck pulses in one write frame → single commit at bit 24, extra clocks ignored; two frames with 1 sck-period sl gap both commit.
